// File: rtl/axis_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axis_rr_arbiter
//
// Purpose:
//   Merges NUM_REQ AXI-Stream requesters onto one downstream AXI-Stream port
//   using round-robin arbitration. Accepted beats pass through a two-entry
//   output stage (main register plus one skid register). Because of the skid
//   register, upstream ready depends only on registered state and never on
//   downstream i_ready.
//
// Handshake (all ports): a beat moves across an interface on a rising clk
//   edge where valid and ready are both high. A source holds valid and its
//   payload stable until that edge. o_ready is one-hot or zero.
//
// Optional feature:
//   AXIS_RR_ARBITER_PKT_LOCK_EN - when defined, arbitration is per packet.
//   Once a requester's first non-last beat is accepted, that requester owns
//   the arbiter (IDLE/LOCKED FSM) until its i_last beat is accepted. When
//   undefined, arbitration is per beat and i_last is only forwarded.
//
// Parameters:
//   NUM_REQ     number of requesters (2..16)
//   DWIDTH      data width per requester
//
// Ports:
//   clk         clock, all state on rising edge
//   rst         asynchronous active-high reset
//   i_valid     per-requester valid (bit k = requester k)
//   i_data      requester k data at [k*DWIDTH +: DWIDTH]
//   i_last      per-requester end-of-packet marker
//   o_ready     per-requester ready (at most one bit high)
//   o_valid     downstream valid
//   o_data      downstream data
//   o_last      downstream end-of-packet
//   i_ready     downstream ready
//   o_grant_id  requester index of the beat on o_data
// ---------------------------------------------------------------------------
module axis_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DWIDTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         i_valid,
  input  logic [NUM_REQ*DWIDTH-1:0]  i_data,
  input  logic [NUM_REQ-1:0]         i_last,
  output logic [NUM_REQ-1:0]         o_ready,
  output logic                       o_valid,
  output logic [DWIDTH-1:0]          o_data,
  output logic                       o_last,
  input  logic                       i_ready,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id
);

  localparam int IDW = $clog2(NUM_REQ);

  // Arbitration state: ptr is the most recently granted requester.
  logic [IDW-1:0]    r_ptr;

  // Output stage: main register drives the outputs, skid absorbs one beat.
  logic              r_main_valid;
  logic [DWIDTH-1:0] r_main_data;
  logic              r_main_last;
  logic [IDW-1:0]    r_main_id;
  logic              r_skid_valid;
  logic [DWIDTH-1:0] r_skid_data;
  logic              r_skid_last;
  logic [IDW-1:0]    r_skid_id;

  // Arbitration results.
  logic [IDW-1:0]    w_rr_sel;
  logic              w_rr_found;
  logic [IDW-1:0]    w_sel;
  logic              w_found;
  logic              w_accept;
  logic              w_ptr_upd;
  logic [DWIDTH-1:0] w_in_data;
  logic              w_in_last;
  logic              w_main_xfer;

  // -------------------------------------------------------------------------
  // Round-robin search: ptr+1, ptr+2, ... with ptr itself checked last.
  // -------------------------------------------------------------------------
  always_comb begin
    logic [IDW-1:0] v_idx;
    w_rr_sel   = '0;
    w_rr_found = 1'b0;
    v_idx      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      v_idx = IDW'((int'(r_ptr) + i) % NUM_REQ);
      if (!w_rr_found && i_valid[v_idx]) begin
        w_rr_found = 1'b1;
        w_rr_sel   = v_idx;
      end
    end
  end

`ifdef AXIS_RR_ARBITER_PKT_LOCK_EN
  // -------------------------------------------------------------------------
  // Packet lock FSM: the owner keeps the grant until its last beat goes in.
  // -------------------------------------------------------------------------
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [IDW-1:0] r_owner;
  logic [IDW-1:0] w_owner_next;

  // While locked, other requesters are ignored even if the owner is idle.
  assign w_sel     = (r_state == ST_LOCKED) ? r_owner : w_rr_sel;
  assign w_found   = (r_state == ST_LOCKED) ? i_valid[r_owner] : w_rr_found;
  // ptr moves only when a packet completes, so fairness is per packet.
  assign w_ptr_upd = w_accept & w_in_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= '0;
    end else begin
      r_state <= w_state_next;
      r_owner <= w_owner_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && !w_in_last) begin
          w_state_next = ST_LOCKED;
          w_owner_next = w_sel;
        end
      end
      ST_LOCKED: begin
        if (w_accept && w_in_last) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end
`else
  assign w_sel     = w_rr_sel;
  assign w_found   = w_rr_found;
  assign w_ptr_upd = w_accept;
`endif

  // -------------------------------------------------------------------------
  // Upstream ready: only the selected requester, only while the skid slot is
  // free. Held low during reset.
  // -------------------------------------------------------------------------
  always_comb begin
    o_ready = '0;
    if (!rst && !r_skid_valid && w_found) begin
      o_ready[w_sel] = 1'b1;
    end
  end

  assign w_accept = |(i_valid & o_ready);

  // Payload of the selected requester.
  always_comb begin
    w_in_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (IDW'(k) == w_sel) begin
        w_in_data = i_data[k*DWIDTH +: DWIDTH];
      end
    end
  end

  assign w_in_last   = i_last[w_sel];
  assign w_main_xfer = r_main_valid & i_ready;

  // -------------------------------------------------------------------------
  // Round-robin pointer. Reset to NUM_REQ-1 so requester 0 is searched first.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= IDW'(NUM_REQ - 1);
    end else if (w_ptr_upd) begin
      r_ptr <= w_sel;
    end
  end

  // -------------------------------------------------------------------------
  // Output stage. The skid can only be full while main is full, and an
  // accept cannot happen while the skid is full, so a draining skid never
  // competes with an incoming beat.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_main_last  <= 1'b0;
      r_main_id    <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_last  <= 1'b0;
      r_skid_id    <= '0;
    end else begin
      if (w_main_xfer) begin
        if (r_skid_valid) begin
          r_main_data  <= r_skid_data;
          r_main_last  <= r_skid_last;
          r_main_id    <= r_skid_id;
          r_skid_valid <= 1'b0;
        end else if (w_accept) begin
          r_main_data <= w_in_data;
          r_main_last <= w_in_last;
          r_main_id   <= w_sel;
        end else begin
          r_main_valid <= 1'b0;
        end
      end else if (!r_main_valid) begin
        if (w_accept) begin
          r_main_valid <= 1'b1;
          r_main_data  <= w_in_data;
          r_main_last  <= w_in_last;
          r_main_id    <= w_sel;
        end
      end else if (w_accept) begin
        // Main is holding a stalled beat; park the new one in the skid.
        r_skid_valid <= 1'b1;
        r_skid_data  <= w_in_data;
        r_skid_last  <= w_in_last;
        r_skid_id    <= w_sel;
      end
    end
  end

  assign o_valid    = r_main_valid;
  assign o_data     = r_main_data;
  assign o_last     = r_main_last;
  assign o_grant_id = r_main_id;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axis_rr_arbiter
//
// Reference model: each requester owns a queue of beats it wants to send.
// The arbiter is modelled as "pick the requester the round-robin rule names,
// accept it while fewer than two beats are in flight", and the output stage
// as a two-deep FIFO (exp_q) whose head must be on the outputs whenever it
// is non-empty. Every transferred beat is appended to log_q for directed
// sequence checks.
// ---------------------------------------------------------------------------
module tb_axis_rr_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 8;
  localparam int IDW = $clog2(NR);
  localparam int BW  = IDW + 1 + DW;   // beat = {id, last, data}

  // Clock / reset.
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR-1:0]    i_valid = '0;
  logic [NR*DW-1:0] i_data  = '0;
  logic [NR-1:0]    i_last  = '0;
  logic [NR-1:0]    o_ready;
  logic             o_valid;
  logic [DW-1:0]    o_data;
  logic             o_last;
  logic             i_ready = 1'b0;
  logic [IDW-1:0]   o_grant_id;

  always #5 clk = ~clk;

  axis_rr_arbiter #(.NUM_REQ(NR), .DWIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .i_last     (i_last),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .o_last     (o_last),
    .i_ready    (i_ready),
    .o_grant_id (o_grant_id)
  );

  // Scoreboard state.
  logic [BW-1:0] src_q [NR][$];
  logic [BW-1:0] exp_q [$];
  logic [BW-1:0] log_q [$];
  bit            pres [NR];
  int            m_ptr;
  bit            m_locked;
  int            m_owner;
  int            wait_cnt [NR];
  int            max_wait;
  int            n_acc;
  int            ready_mode;   // 0: low, 1: high, 2: random
  int            valid_pct;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] mk_beat(input int id, input bit last, input int data);
    return {IDW'(id), last, DW'(data)};
  endfunction

  function automatic int log_id(input int i);
    if (i < log_q.size()) return int'(log_q[i][BW-1 -: IDW]);
    return -1;
  endfunction

  function automatic int log_data(input int i);
    if (i < log_q.size()) return int'(log_q[i][DW-1:0]);
    return -1;
  endfunction

  function automatic int src_pending();
    int s = 0;
    for (int k = 0; k < NR; k++) s += src_q[k].size();
    return s;
  endfunction

  // One clock cycle: drive, check outputs against the model, advance model.
  task automatic step();
    bit            found;
    bit            acc;
    bit            xfer;
    int            g;
    logic [BW-1:0] b;
    logic [NR-1:0] exp_rdy;
    @(negedge clk);
    for (int k = 0; k < NR; k++) begin
      if (!pres[k] && src_q[k].size() > 0 && $urandom_range(0, 99) < valid_pct) pres[k] = 1'b1;
      i_valid[k] = pres[k];
      if (pres[k]) begin
        i_data[k*DW +: DW] = src_q[k][0][DW-1:0];
        i_last[k]          = src_q[k][0][DW];
      end else begin
        i_data[k*DW +: DW] = DW'($urandom);
        i_last[k]          = 1'($urandom_range(0, 1));
      end
    end
    case (ready_mode)
      0:       i_ready = 1'b0;
      1:       i_ready = 1'b1;
      default: i_ready = 1'($urandom_range(0, 1));
    endcase
    #1;
    check_eq("o_valid", o_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      check_eq("o_data", o_data, exp_q[0][DW-1:0]);
      check_eq("o_last", o_last, exp_q[0][DW]);
      check_eq("o_grant_id", o_grant_id, exp_q[0][BW-1 -: IDW]);
    end
    // Grant rule: locked owner, else first valid after ptr (ptr last).
    found = 1'b0;
    g     = 0;
    if (m_locked) begin
      g     = m_owner;
      found = pres[g];
    end else begin
      for (int n = 1; n <= NR; n++) begin
        int j;
        j = (m_ptr + n) % NR;
        if (!found && pres[j]) begin
          found = 1'b1;
          g     = j;
        end
      end
    end
    acc     = found && exp_q.size() < 2;
    exp_rdy = '0;
    if (acc) exp_rdy[g] = 1'b1;
    check_eq("o_ready", o_ready, exp_rdy);
    xfer = exp_q.size() > 0 && i_ready;
    if (xfer) begin
      b = exp_q.pop_front();
      log_q.push_back(b);
    end
    if (acc) begin
      b = src_q[g].pop_front();
      exp_q.push_back(b);
      pres[g] = 1'b0;
      n_acc++;
`ifdef AXIS_RR_ARBITER_PKT_LOCK_EN
      if (m_locked) begin
        if (b[DW]) begin
          m_locked = 1'b0;
          m_ptr    = g;
        end
      end else if (!b[DW]) begin
        m_locked = 1'b1;
        m_owner  = g;
      end else begin
        m_ptr = g;
      end
`else
      m_ptr = g;
`endif
      for (int k = 0; k < NR; k++) begin
        if (k != g && pres[k]) begin
          wait_cnt[k]++;
          if (wait_cnt[k] > max_wait) max_wait = wait_cnt[k];
        end
      end
      wait_cnt[g] = 0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Reset applied at a falling edge with inputs left as they are, so the
  // o_ready gating during reset is exercised with live requests.
  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_o_valid", o_valid, 0);
    check_eq("rst_o_data", o_data, 0);
    check_eq("rst_o_last", o_last, 0);
    check_eq("rst_o_grant_id", o_grant_id, 0);
    check_eq("rst_o_ready", o_ready, 0);
    repeat (cycles) @(negedge clk);
    rst     = 1'b0;
    i_valid = '0;
    for (int k = 0; k < NR; k++) begin
      src_q[k].delete();
      pres[k]     = 1'b0;
      wait_cnt[k] = 0;
    end
    exp_q.delete();
    log_q.delete();
    m_ptr    = NR - 1;
    m_locked = 1'b0;
    m_owner  = 0;
    n_acc    = 0;
  endtask

  initial begin
    int total;
    int guard;
    int e_seq_id [5];
    int e_alt_id [6];
    ready_mode = 1;
    valid_pct  = 100;
    max_wait   = 0;
    i_valid    = '1;
    do_reset(3);

    // Four requesters always valid, downstream always ready.
    for (int k = 0; k < NR; k++)
      for (int b = 0; b < 5; b++) src_q[k].push_back(mk_beat(k, 1'b1, 16 + k));
    run(8);
    e_seq_id = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      check_eq("seq_id", log_id(i), e_seq_id[i]);
      check_eq("seq_data", log_data(i), 16 + e_seq_id[i]);
    end
    check_eq("seq_throughput", log_q.size(), 7);

    // Requesters 0 and 2 only.
    do_reset(1);
    for (int b = 0; b < 6; b++) begin
      src_q[0].push_back(mk_beat(0, 1'b1, 32 + b));
      src_q[2].push_back(mk_beat(2, 1'b1, 64 + b));
    end
    run(8);
    e_alt_id = '{0, 2, 0, 2, 0, 2};
    for (int i = 0; i < 6; i++) check_eq("alt_id", log_id(i), e_alt_id[i]);

    // Downstream stalled: exactly two beats fit, then backpressure.
    do_reset(1);
    ready_mode = 0;
    for (int b = 0; b < 4; b++) begin
      src_q[0].push_back(mk_beat(0, 1'b1, 80 + b));
      src_q[1].push_back(mk_beat(1, 1'b1, 96 + b));
    end
    run(6);
    check_eq("stall_accepts", n_acc, 2);
    ready_mode = 1;
    run(10);
    check_eq("stall_first_id", log_id(0), 0);
    check_eq("stall_second_id", log_id(1), 1);
    check_eq("stall_first_data", log_data(0), 80);

    // Three-beat packet from requester 1 racing requester 2.
    do_reset(1);
    for (int b = 0; b < 3; b++) begin
      src_q[1].push_back(mk_beat(1, b == 2, 160 + b));
      src_q[2].push_back(mk_beat(2, 1'b1, 176 + b));
    end
    run(10);
`ifdef AXIS_RR_ARBITER_PKT_LOCK_EN
    check_eq("pkt_id0", log_id(0), 1);
    check_eq("pkt_id1", log_id(1), 1);
    check_eq("pkt_id2", log_id(2), 1);
    check_eq("pkt_id3", log_id(3), 2);
`else
    check_eq("pkt_id0", log_id(0), 1);
    check_eq("pkt_id1", log_id(1), 2);
    check_eq("pkt_id2", log_id(2), 1);
    check_eq("pkt_id3", log_id(3), 2);
`endif

    // Fill main and skid, then reset mid-transfer.
    do_reset(1);
    ready_mode = 0;
    for (int b = 0; b < 2; b++) begin
      src_q[1].push_back(mk_beat(1, 1'b1, 200 + b));
      src_q[2].push_back(mk_beat(2, 1'b1, 210 + b));
    end
    run(4);
    check_eq("full_accepts", n_acc, 2);
    do_reset(1);
    run(3);
    ready_mode = 1;
    src_q[0].push_back(mk_beat(0, 1'b1, 220));
    src_q[2].push_back(mk_beat(2, 1'b1, 221));
    run(5);
    check_eq("post_rst_first_id", log_id(0), 0);
    check_eq("post_rst_first_data", log_data(0), 220);

    // Randomized traffic with random packet lengths and backpressure.
    do_reset(1);
    max_wait   = 0;
    total      = 0;
    ready_mode = 2;
    valid_pct  = 50;
    for (int k = 0; k < NR; k++) begin
      int n;
      n = 0;
      while (n < 100) begin
        int len;
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) src_q[k].push_back(mk_beat(k, b == len - 1, $urandom_range(0, 255)));
        n     += len;
        total += len;
      end
    end
    run(1000);
    ready_mode = 1;
    valid_pct  = 100;
    guard      = 0;
    while ((src_pending() > 0 || exp_q.size() > 0) && guard < 3000) begin
      step();
      guard++;
    end
    check_eq("drain_in_time", guard < 3000, 1);
    check_eq("no_loss", log_q.size(), total);
`ifndef AXIS_RR_ARBITER_PKT_LOCK_EN
    check_eq("max_wait_bound", max_wait <= NR - 1, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
